bitcount_engine: RTL and testbench

- Parametrised successor to the team's 8-bit ASMD bit counter.
- Accepts a DATA_W-bit word over a valid/ready handshake and scans it STEP bits per cycle.
- Returns one of four statistics over a valid/ready result handshake: ones count, zeros count, parity or bit length.
- Used as a reusable datapath+FSM block wherever the design needs per-word bit statistics. Back-pressure on both sides replaces the old LA/s/Done level protocol.

---
 rtl/bitcount_pkg.sv | 24 ++
 rtl/bitcount_chunk.sv | 27 ++
 rtl/bitcount_engine.sv | 143 ++++++++++++++
 tb/tb_bitcount_engine.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bitcount_pkg.sv
// Shared types and helpers for the bit-statistics engine.
package bitcount_pkg;

    // Statistic selected for a word; encoding is visible on the mode port.
    typedef enum logic [1:0] {
        POP    = 2'd0,
        ZERO   = 2'd1,
        PARITY = 2'd2,
        BITLEN = 2'd3
    } mode_t;

    // Control states of the scan FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result width needed to hold any count from 0 to data_w inclusive.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/bitcount_chunk.sv
// Combinational statistics of one STEP-bit slice: number of ones and
// the index of the highest set bit plus one (0 when the slice is empty).
module bitcount_chunk #(
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic [STEP-1:0]  slice,
    output logic [CNT_W-1:0] ones,
    output logic [CNT_W-1:0] top_idx
);

    // Walk the slice from LSB to MSB; the last set bit seen wins top_idx.
    always_comb begin
        ones    = {CNT_W{1'b0}};
        top_idx = {CNT_W{1'b0}};
        for (int i = 0; i < STEP; i++) begin
            if (slice[i]) begin
                ones    = ones + {{(CNT_W-1){1'b0}}, 1'b1};
                top_idx = CNT_W'(i + 1);
            end else begin
                ones    = ones;
                top_idx = top_idx;
            end
        end
    end

endmodule

// File: rtl/bitcount_engine.sv
// Per-word bit statistics engine: accepts a word over valid/ready, scans it
// STEP bits per cycle and returns ones/zeros count, parity or bit length.
module bitcount_engine
    import bitcount_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STEP   = 1,
    parameter int CNT_W  = cnt_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  result,
    output logic              busy
);

    state_t            state_r, state_next_s;
    logic [DATA_W-1:0] a_r, a_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    mode_t             mode_r, mode_next_s;

    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic [CNT_W-1:0]  result_r;

    logic [DATA_W-1:0] a_upper_s;
    logic [CNT_W-1:0]  chunk_ones_s;
    logic [CNT_W-1:0]  chunk_top_s;
    logic [CNT_W-1:0]  inc_s;
    logic              accept_s;

    // Parity is the LSB of the ones count, presented zero-extended.
    function automatic logic [CNT_W-1:0] fmt_result(input logic [CNT_W-1:0] c,
                                                    input mode_t m);
        if (m == PARITY) begin
            return {{(CNT_W-1){1'b0}}, c[0]};
        end else begin
            return c;
        end
    endfunction

    assign a_upper_s = a_r >> STEP;
    assign accept_s  = in_valid && in_ready_r;

    bitcount_chunk #(
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_chunk (
        .slice   (a_r[STEP-1:0]),
        .ones    (chunk_ones_s),
        .top_idx (chunk_top_s)
    );

    // Per-cycle increment: ones in the low slice, or the bit-length contribution.
    always_comb begin
        inc_s = chunk_ones_s;
        case (mode_r)
            BITLEN: begin
                if (a_upper_s != {DATA_W{1'b0}}) begin
                    inc_s = CNT_W'(STEP);
                end else begin
                    inc_s = chunk_top_s;
                end
            end
            default: inc_s = chunk_ones_s;
        endcase
    end

    // Next-state and datapath update for the scan FSM.
    always_comb begin
        state_next_s = state_r;
        a_next_s     = a_r;
        cnt_next_s   = cnt_r;
        mode_next_s  = mode_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    a_next_s     = (mode_t'(mode) == ZERO) ? ~data : data;
                    cnt_next_s   = {CNT_W{1'b0}};
                    mode_next_s  = mode_t'(mode);
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (a_r == {DATA_W{1'b0}}) begin
                    state_next_s = DONE;
                end else begin
                    a_next_s     = a_upper_s;
                    cnt_next_s   = cnt_r + inc_s;
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs derived from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= {DATA_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            mode_r      <= POP;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            result_r    <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            a_r         <= a_next_s;
            cnt_r       <= cnt_next_s;
            mode_r      <= mode_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s == RUN);
            result_r    <= (state_next_s == DONE) ? fmt_result(cnt_next_s, mode_next_s)
                                                  : {CNT_W{1'b0}};
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;

endmodule

// File: tb/tb_bitcount_engine.sv
// Directed, table-driven bench for bitcount_engine in two configurations:
// DATA_W=8/STEP=1 (narrow) and DATA_W=16/STEP=4 (wide).
module tb_bitcount_engine;
    import bitcount_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic [1:0]  mode;
    logic        out_ready;

    logic        n_in_valid, n_in_ready, n_out_valid, n_busy;
    logic [3:0]  n_result;
    logic        w_in_valid, w_in_ready, w_out_valid, w_busy;
    logic [4:0]  w_result;

    logic        wide;
    logic        cur_in_ready, cur_out_valid, cur_busy;
    logic [4:0]  cur_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bitcount_engine #(.DATA_W(8), .STEP(1)) u_narrow (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .data      (data[7:0]),
        .mode      (mode),
        .out_valid (n_out_valid),
        .out_ready (out_ready),
        .result    (n_result),
        .busy      (n_busy)
    );

    bitcount_engine #(.DATA_W(16), .STEP(4)) u_wide (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .data      (data),
        .mode      (mode),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .result    (w_result),
        .busy      (w_busy)
    );

    assign cur_in_ready  = wide ? w_in_ready  : n_in_ready;
    assign cur_out_valid = wide ? w_out_valid : n_out_valid;
    assign cur_busy      = wide ? w_busy      : n_busy;
    assign cur_result    = wide ? w_result    : {1'b0, n_result};

    typedef struct {
        logic        wide;
        logic [1:0]  mode;
        logic [15:0] data;
        int          exp_result;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Accept one word, measure latency to out_valid, check result, then handshake.
    task automatic run_word(input logic w, input logic [1:0] m, input logic [15:0] d,
                            input int er, input int el, input string nm);
        int cyc;
        wide = w;
        @(negedge clk);
        check({nm, " in_ready idle"}, int'(cur_in_ready), 1);
        if (w) w_in_valid = 1'b1; else n_in_valid = 1'b1;
        data = d;
        mode = m;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n_in_valid = 1'b0;
        check({nm, " in_ready after accept"}, int'(cur_in_ready), 0);
        cyc = 0;
        while (cur_out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, " latency"}, cyc, el);
        check({nm, " result"}, int'(cur_result), er);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, " out_valid drop"}, int'(cur_out_valid), 0);
        check({nm, " in_ready return"}, int'(cur_in_ready), 1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, POP,    16'h00AE, 5,  9, "n pop AE"};
        vecs[1]  = '{1'b0, ZERO,   16'h00AE, 3,  8, "n zero AE"};
        vecs[2]  = '{1'b0, PARITY, 16'h00AE, 1,  9, "n parity AE"};
        vecs[3]  = '{1'b0, POP,    16'h0000, 0,  1, "n pop 00"};
        vecs[4]  = '{1'b0, BITLEN, 16'h002C, 6,  7, "n bitlen 2C"};
        vecs[5]  = '{1'b0, ZERO,   16'h00FF, 0,  1, "n zero FF"};
        vecs[6]  = '{1'b0, BITLEN, 16'h0080, 8,  9, "n bitlen 80"};
        vecs[7]  = '{1'b1, BITLEN, 16'h0013, 5,  3, "w bitlen 0013"};
        vecs[8]  = '{1'b1, POP,    16'hFFFF, 16, 5, "w pop FFFF"};
        vecs[9]  = '{1'b1, ZERO,   16'hFFF0, 4,  2, "w zero FFF0"};
        vecs[10] = '{1'b1, PARITY, 16'h8001, 0,  5, "w parity 8001"};
        vecs[11] = '{1'b1, BITLEN, 16'h0100, 9,  4, "w bitlen 0100"};

        reset      = 1'b1;
        data       = 16'h0000;
        mode       = 2'd0;
        out_ready  = 1'b0;
        n_in_valid = 1'b0;
        w_in_valid = 1'b0;
        wide       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst n in_ready", int'(n_in_ready), 1);
        check("rst n out_valid", int'(n_out_valid), 0);
        check("rst n busy", int'(n_busy), 0);
        check("rst n result", int'(n_result), 0);
        check("rst w in_ready", int'(w_in_ready), 1);
        check("rst w out_valid", int'(w_out_valid), 0);
        check("rst w result", int'(w_result), 0);

        for (int i = 0; i < 12; i++) begin
            run_word(vecs[i].wide, vecs[i].mode, vecs[i].data,
                     vecs[i].exp_result, vecs[i].exp_lat, vecs[i].name);
        end

        // Busy window, input changes during RUN, back-pressure, held in_valid.
        wide = 1'b0;
        @(negedge clk);
        n_in_valid = 1'b1;
        data = 16'h00AE;
        mode = POP;
        @(posedge clk); #1;
        data = 16'h00FF;
        mode = ZERO;
        check("seqA busy t", int'(n_busy), 1);
        repeat (8) @(posedge clk);
        #1;
        check("seqA busy t+8", int'(n_busy), 1);
        check("seqA out_valid t+8", int'(n_out_valid), 0);
        @(posedge clk); #1;
        check("seqA busy t+9", int'(n_busy), 0);
        check("seqA out_valid t+9", int'(n_out_valid), 1);
        check("seqA result", int'(n_result), 5);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("seqA bp out_valid", int'(n_out_valid), 1);
            check("seqA bp result", int'(n_result), 5);
            check("seqA bp in_ready", int'(n_in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("seqA hs in_ready", int'(n_in_ready), 1);
        check("seqA hs out_valid", int'(n_out_valid), 0);
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        check("seqA held accept in_ready", int'(n_in_ready), 0);
        check("seqA held accept busy", int'(n_busy), 1);
        @(posedge clk); #1;
        check("seqA held out_valid", int'(n_out_valid), 1);
        check("seqA held result", int'(n_result), 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("seqA final in_ready", int'(n_in_ready), 1);

        // Reset mid-RUN aborts the word; a fresh word then completes.
        @(negedge clk);
        n_in_valid = 1'b1;
        data = 16'h00AE;
        mode = POP;
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("seqB rst in_ready", int'(n_in_ready), 1);
        check("seqB rst out_valid", int'(n_out_valid), 0);
        check("seqB rst result", int'(n_result), 0);
        check("seqB rst busy", int'(n_busy), 0);
        run_word(1'b0, BITLEN, 16'h002C, 6, 7, "seqB fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
